// File: rtl/uart_pkg.sv
// Shared definitions for the host UART receive path.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 430;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
`timescale 1ns/1ps
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_reg <= {STAGES{RST_VAL}};
    else     chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/uart_host_rx.sv
// 8N1 UART receiver: mid-bit sampling, framing-error detection and a
// single-entry valid/ready holding register with sticky overrun.
`timescale 1ns/1ps
module uart_host_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic rxs;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rxs)
  );

  uart_state_t            state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [2:0]             idx_reg, idx_next;
  logic [UART_DATA_W-1:0] shift_reg, shift_next;
  logic [UART_DATA_W-1:0] data_reg;
  logic                   valid_reg, frame_err_reg, overrun_reg;
  logic                   tick, byte_done, stop_bad, handshake;

  assign tick      = (cnt_reg == '0);
  assign handshake = valid_reg & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    byte_done  = 1'b0;
    stop_bad   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxs) begin
          state_next = START;
          cnt_next   = HALF_LOAD;
          idx_next   = '0;
        end
      end
      START: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (rxs) begin
          state_next = IDLE;
        end else begin
          state_next = DATA;
          cnt_next   = FULL_LOAD;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else begin
          shift_next[idx_reg] = rxs;
          cnt_next            = FULL_LOAD;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        // Returning to IDLE at mid-stop lets a following start bit be caught early.
        if (!tick) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (rxs) begin
          byte_done  = 1'b1;
          state_next = IDLE;
        end else begin
          stop_bad   = 1'b1;
          state_next = BREAK;
        end
      end
      BREAK: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= stop_bad;
      // A completing byte is only dropped when the register is full and not being drained.
      if (byte_done && (!valid_reg || ready)) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (handshake) begin
        valid_reg <= 1'b0;
      end
      if (handshake)                   overrun_reg <= 1'b0;
      else if (byte_done && valid_reg) overrun_reg <= 1'b1;
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_host_rx.sv
// Self-checking bench for uart_host_rx: frame-level reference model plus
// directed scenarios and randomized frames with random ready.
`timescale 1ns/1ps
module tb_uart_host_rx;

  localparam int CPB  = 430;
  localparam int SYNC = 2;
  // Edges from the first clock after the pin falls to the stop-bit sample.
  localparam int LAT  = SYNC + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  always #10 clk = ~clk;

  uart_host_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each frame sent becomes an event at its stop-sample edge.
  typedef struct {
    int         t;
    logic [7:0] b;
    bit         ok;
  } ev_t;
  ev_t evq[$];

  typedef struct packed {
    logic       v;
    logic       o;
    logic       f;
    logic [7:0] d;
  } mstate_t;
  mstate_t m;

  function automatic mstate_t step(mstate_t s, logic rdy, bit has_ev, bit ok, logic [7:0] b);
    mstate_t n = s;
    n.f = 1'b0;
    if (s.v && rdy) begin
      n.v = 1'b0;
      n.o = 1'b0;
    end
    if (has_ev && ok) begin
      if (s.v && !rdy) n.o = 1'b1;
      else begin
        n.v = 1'b1;
        n.d = b;
      end
    end
    if (has_ev && !ok) n.f = 1'b1;
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m <= '0;
    end else if (evq.size() > 0 && evq[0].t == cyc + 1) begin
      m <= step(m, ready, 1'b1, evq[0].ok, evq[0].b);
      void'(evq.pop_front());
    end else begin
      m <= step(m, ready, 1'b0, 1'b0, 8'h00);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", {7'd0, valid}, {7'd0, m.v});
      check("frame_err", {7'd0, frame_err}, {7'd0, m.f});
      check("overrun", {7'd0, overrun}, {7'd0, m.o});
      if (m.v) check("data", data, m.d);
    end
  end

  // Observation helpers feeding the literal checks.
  logic [7:0] log_q[$];
  int         fe_total = 0;
  int         last_rise = 0;
  logic       valid_d = 1'b0;

  always @(posedge clk) begin
    if (!rst && valid === 1'b1 && ready === 1'b1) log_q.push_back(data);
    if (!rst && frame_err === 1'b1) fe_total <= fe_total + 1;
  end

  always @(negedge clk) begin
    valid_d <= valid;
    if (valid === 1'b1 && valid_d !== 1'b1) last_rise <= cyc;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic idle(input int nbits);
    rx = 1'b1;
    wait_cycles(nbits * CPB);
  endtask

  // Sends one 8N1 frame; abort_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send(input logic [7:0] b, input bit ok, input int extra_low, input int abort_bit);
    logic [9:0] bits;
    ev_t        e;
    bits = {ok, b, 1'b0};
    if (abort_bit < 0) begin
      e.t  = cyc + 1 + LAT;
      e.b  = b;
      e.ok = ok;
      evq.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      if (abort_bit >= 0 && i == abort_bit + 1) begin
        wait_cycles(CPB / 2);
        rst = 1'b1;
        wait_cycles(4);
        check("rst_mid_valid", {7'd0, valid}, 8'd0);
        check("rst_mid_data", data, 8'd0);
        rst = 1'b0;
        wait_cycles(1);
        check("rst_after_valid", {7'd0, valid}, 8'd0);
        wait_cycles(CPB - CPB / 2 - 5);
      end else begin
        wait_cycles(CPB);
      end
    end
    if (extra_low > 0) begin
      rx = 1'b0;
      wait_cycles(extra_low * CPB);
    end
    rx = 1'b1;
  endtask

  task automatic check_log(input string nm, input int idx, input logic [7:0] exp);
    if (log_q.size() > idx) begin
      check(nm, log_q[idx], exp);
    end else begin
      nchk++;
      nerr++;
      $display("FAIL %s: got no byte expected %h", nm, exp);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, fe0, t_fall;
    logic [7:0] rb;
    bit ok;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_valid", {7'd0, valid}, 8'd0);
    check("reset_data", data, 8'd0);
    check("reset_frame_err", {7'd0, frame_err}, 8'd0);
    check("reset_overrun", {7'd0, overrun}, 8'd0);
    rst = 1'b0;
    ready = 1'b1;
    idle(1);

    // Single byte with latency check.
    base = log_q.size(); fe0 = fe_total; t_fall = cyc;
    send(8'hE6, 1'b1, 0, -1);
    idle(2);
    check_int("e6_count", log_q.size() - base, 1);
    check_log("e6_data", base, 8'hE6);
    check_int("e6_latency", last_rise - t_fall, 4088);
    check_int("e6_frame_err", fe_total - fe0, 0);
    check("e6_overrun", {7'd0, overrun}, 8'd0);

    // Back-to-back frames without idle gap.
    base = log_q.size(); fe0 = fe_total;
    send(8'h00, 1'b1, 0, -1);
    send(8'hFF, 1'b1, 0, -1);
    send(8'hA5, 1'b1, 0, -1);
    idle(2);
    check_int("b2b_count", log_q.size() - base, 3);
    check_log("b2b_0", base, 8'h00);
    check_log("b2b_1", base + 1, 8'hFF);
    check_log("b2b_2", base + 2, 8'hA5);
    check_int("b2b_frame_err", fe_total - fe0, 0);

    // Overrun with consumer stalled.
    ready = 1'b0;
    base = log_q.size();
    send(8'h55, 1'b1, 0, -1);
    send(8'h3C, 1'b1, 0, -1);
    idle(2);
    check("ovr_data", data, 8'h55);
    check("ovr_valid", {7'd0, valid}, 8'd1);
    check("ovr_flag", {7'd0, overrun}, 8'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("ovr_drain_valid", {7'd0, valid}, 8'd0);
    check("ovr_drain_flag", {7'd0, overrun}, 8'd0);
    check_int("ovr_count", log_q.size() - base, 1);
    check_log("ovr_byte", base, 8'h55);
    ready = 1'b1;

    // Short low glitch.
    base = log_q.size(); fe0 = fe_total;
    rx = 1'b0;
    wait_cycles(100);
    idle(1);
    check_int("glitch_count", log_q.size() - base, 0);
    check_int("glitch_frame_err", fe_total - fe0, 0);
    check("glitch_valid", {7'd0, valid}, 8'd0);

    // Framing error followed by held-low line, then recovery.
    base = log_q.size(); fe0 = fe_total;
    send(8'h81, 1'b0, 3, -1);
    idle(1);
    check_int("brk_frame_err", fe_total - fe0, 1);
    check_int("brk_count", log_q.size() - base, 0);
    send(8'h42, 1'b1, 0, -1);
    idle(2);
    check_int("brk_next_count", log_q.size() - base, 1);
    check_log("brk_next_data", base, 8'h42);
    check_int("brk_frame_err_total", fe_total - fe0, 1);

    // Reset in the middle of a frame.
    base = log_q.size();
    send(8'hF0, 1'b1, 0, 4);
    idle(1);
    send(8'h0F, 1'b1, 0, -1);
    idle(2);
    check_int("rst_count", log_q.size() - base, 1);
    check_log("rst_data", base, 8'h0F);

    // Randomized frames with random consumer readiness.
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      send(rb, ok, 0, -1);
      idle(ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    idle(2);
    check_int("model_drained", evq.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/uart_host_rx.md
Name: uart_host_rx

Overview:
Serial receiver for the host-to-device UART link (8N1, LSB first, idle high) feeding the perceptron core. It synchronises the asynchronous host line, validates the start bit, samples each bit at mid-period and presents the byte through a single-entry valid/ready holding register. It flags framing errors and overruns so the core can drop corrupted commands.

Parameters:
CLKS_PER_BIT, 430, system clocks per baud period (50 MHz clock, 8600 ns bit); legal range ≥ 8.
SYNC_STAGES, 2, flops in the rx input synchroniser; legal range 2–3.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
rx  in  1  host serial line, asynchronous, idle high
data  out  8  received byte; stable while valid=1
valid  out  1  holding register full
ready  in  1  consumer accepts the byte when valid&ready on a clk edge
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  sticky: a completed byte was dropped because the holding register was full

Behaviour:
- Reset (async assert, sync release): state=IDLE, synchroniser flops=1, data=0, valid=0, frame_err=0, overrun=0, counters=0.
- The rx line passes through SYNC_STAGES flops; only the synchronised value (rxs) is used internally.
- States:
  - IDLE: on rxs=0 -> START, bit counter cleared, baud counter loaded with CLKS_PER_BIT/2 − 1 (integer division).
  - START: when counter=0, sample rxs. If rxs=1 (glitch) -> IDLE with no flags. If rxs=0 -> DATA, counter reloaded with CLKS_PER_BIT − 1.
  - DATA: each counter expiry shifts rxs into bit[idx], idx 0..7 (LSB first), then reloads. After bit 7 -> STOP.
  - STOP: at expiry, sample rxs.
    - rxs=1: byte complete -> IDLE.
    - rxs=0: frame_err pulses 1 cycle, byte discarded -> BREAK.
  - BREAK: wait for rxs=1, then -> IDLE. A held-low line never produces bytes.
- Completion and hand-off: on byte complete, valid rises on the cycle after the stop sample and data holds the byte.
  - Latency: falling edge at the rx pin to valid = SYNC_STAGES + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, ±1.
- Handshake:
  - valid stays high until a cycle with valid&ready, after which valid=0 next cycle.
  - ready while valid=0 has no effect.
- Overrun: byte completes while valid=1 and ready=0 -> new byte dropped, data unchanged, overrun=1. overrun clears on the next valid&ready handshake.
- Completion in the same cycle as a handshake: the new byte is loaded, valid stays 1, overrun is not set.
- Back-to-back frames: a start bit immediately after the stop sample point is detected. The receiver returns to IDLE at mid-stop-bit, which tolerates ±4% baud error.
- Reset mid-frame: immediate abort to IDLE, partial byte lost, all outputs at reset values.
- All counters are sized with $clog2(CLKS_PER_BIT) bits. The bit index is 3 bits and never wraps past 7.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W=8
  - default CLKS_PER_BIT=430
  - state enum (IDLE, START, DATA, STOP, BREAK)
- Sub-module sync_ff (parameter STAGES, reset value 1) is the input synchroniser and is reusable by other async inputs.
- The baud counter, FSM and holding register stay in uart_host_rx.

Test Plan:
- Reset then send 0xE6 (8N1, 8600 ns bits), ready=1 -> one valid pulse with data=0xE6, frame_err=0, overrun=0.
- Send 0x00, 0xFF, 0xA5 back-to-back with no idle gap, ready=1 -> three bytes in order, no flags.
- Send 0x55 then 0x3C with ready=0 throughout -> data=0x55 held, overrun=1. Then raise ready for 1 cycle -> valid=0, overrun=0.
- 2000 ns low glitch on rx (shorter than a half bit) -> no valid, no frame_err, FSM back in IDLE.
- Frame 0x81 with stop bit forced low, rx held low 3 bit periods then high -> frame_err pulses exactly once, no valid. The next 0x42 is received correctly.
- Assert rst during bit 4 of 0xF0, release, send 0x0F -> only 0x0F delivered; valid=0 during and immediately after reset.
